// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: imem req/ack port plus the issue side to the decoder.
// master = fetch unit, slave = instruction memory / decode / ALU side.
interface instr_fetch_unit_if #(
  parameter int PC_W = 64
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [10:0]     opcode;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic            branch;
  logic            uncond_branch;
  logic            zero;
  logic [PC_W-1:0] branch_offset;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc,
    input  imem_ack, imem_rdata, instr_ready,
    input  branch, uncond_branch, zero, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc,
    output imem_ack, imem_rdata, instr_ready,
    output branch, uncond_branch, zero, branch_offset
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, one-at-a-time imem fetch, next-PC select.
// Optional FETCH_PERF_CNT_EN adds a saturating fetch-stall counter port.
module instr_fetch_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 CLK,
  input  logic                 resetl,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]          stall_cnt,
`endif
  instr_fetch_unit_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;
  logic [31:0]     instr_q;
  logic            req;
  logic            valid;
  logic            take;
  logic            fire;
  logic            retire;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode straight from state so reset drops them at once
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        req = 1'b1;
        if (bus.imem_ack) state_d = ISSUE;
      end
      ISSUE: begin
        valid = 1'b1;
        if (bus.instr_ready) state_d = FETCH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fire   = req & bus.imem_ack;
  assign retire = valid & bus.instr_ready;
  assign take   = bus.uncond_branch
                | (bus.branch & bus.zero);

  always_comb begin
    next_pc = pc_q + PC_W'(4);
    unique case (1'b1)
      take:    next_pc = pc_q
                       + (bus.branch_offset << 2);
      default: next_pc = pc_q + PC_W'(4);
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      if (fire)   instr_q <= bus.imem_rdata;
      if (retire) pc_q    <= next_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      stall_cnt <= 32'h0;
    end else if (req && !bus.imem_ack
                 && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:21];
  assign bus.instr_valid = valid;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Memory returns ADD at address 0, an address-derived word elsewhere.
module tb_instr_fetch_unit;

  logic CLK = 1'b0;
  logic resetl = 1'b0;
  bit   spur = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 CLK = ~CLK;

  instr_fetch_unit_if #(.PC_W(64)) bus ();

  assign bus.imem_rdata = spur ? 32'hDEAD_BEEF
    : (bus.imem_addr == 64'h0) ? 32'h8B02_0020
    : (bus.imem_addr[31:0] ^ 32'h1234_0000);

  instr_fetch_unit #(
    .PC_W(64),
    .RESET_PC(64'h0)
  ) dut (
    .CLK(CLK),
    .resetl(resetl),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .bus(bus)
  );

  task automatic start(input logic ack);
    resetl = 1'b0;
    spur = 1'b0;
    bus.imem_ack = ack;
    bus.instr_ready = 1'b1;
    bus.branch = 1'b0;
    bus.uncond_branch = 1'b0;
    bus.zero = 1'b0;
    bus.branch_offset = '0;
    @(negedge CLK);
    resetl = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wait_issue(input string tag);
    for (int i = 0; i < 20 && bus.instr_valid !== 1'b1; i++)
      @(negedge CLK);
    n_tests++;
    if (bus.instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: instr_valid=%b required 1",
               tag, bus.instr_valid);
    end
  endtask

  task automatic retire(input logic b, input logic u,
                        input logic z, input logic [63:0] off);
    bus.branch = b;
    bus.uncond_branch = u;
    bus.zero = z;
    bus.branch_offset = off;
    bus.instr_ready = 1'b1;
    @(negedge CLK);
    bus.branch = 1'bx;
    bus.uncond_branch = 1'bx;
    bus.zero = 1'bx;
  endtask

  task automatic test_reset;
    resetl = 1'b0;
    bus.imem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    bus.branch = 1'b0;
    bus.uncond_branch = 1'b0;
    bus.zero = 1'b0;
    bus.branch_offset = '0;
    repeat (3) @(negedge CLK);
    n_tests++;
    if ({bus.imem_req, bus.instr_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_req_valid got %b required 00",
               {bus.imem_req, bus.instr_valid});
    end
    n_tests++;
    if (bus.pc !== 64'h0 || bus.imem_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_pc got %h/%h required 0",
               bus.pc, bus.imem_addr);
    end
    n_tests++;
    if (bus.instr !== 32'h0 || bus.opcode !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_instr got %h/%h required 0",
               bus.instr, bus.opcode);
    end
`ifdef FETCH_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_stall got %0d required 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_sequence;
    logic [65:0] exp;
    logic [65:0] got;
    start(1'b1);
    for (int i = 0; i < 8; i++) begin
      exp = {(i % 2) == 0, (i % 2) == 1, 64'(i / 2 * 4)};
      got = {bus.imem_req, bus.instr_valid, bus.imem_addr};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL seq[%0d] req/valid/addr got %h required %h",
                 i, got, exp);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_opcode;
    start(1'b1);
    wait_issue("opcode");
    n_tests++;
    if (bus.instr !== 32'h8B02_0020 || bus.pc !== 64'h0) begin
      n_fail++;
      $display("FAIL add_instr got %h pc %h required 8b020020 pc 0",
               bus.instr, bus.pc);
    end
    n_tests++;
    if (bus.opcode !== 11'b10001011000) begin
      n_fail++;
      $display("FAIL add_opcode got %b required 10001011000",
               bus.opcode);
    end
  endtask

  task automatic test_cbz;
    logic [2:0]  ctl [3];
    logic [63:0] exp [3];
    ctl = '{3'b101, 3'b100, 3'b110};
    exp = '{64'h38, 64'h44, 64'h38};
    for (int k = 0; k < 3; k++) begin
      start(1'b1);
      wait_issue("cbz_a");
      retire(1'b0, 1'b1, 1'b0, 64'd16);
      n_tests++;
      if (bus.imem_addr !== 64'h40) begin
        n_fail++;
        $display("FAIL cbz_goto got %h required 40", bus.imem_addr);
      end
      wait_issue("cbz_b");
      retire(ctl[k][2], ctl[k][1], ctl[k][0], -64'sd2);
      n_tests++;
      if (bus.imem_addr !== exp[k] || bus.imem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL cbz[%0d] addr got %h required %h",
                 k, bus.imem_addr, exp[k]);
      end
    end
  endtask

  task automatic test_uncond;
    start(1'b1);
    wait_issue("b_a");
    retire(1'b0, 1'b1, 1'b0, 64'd64);
    wait_issue("b_b");
    n_tests++;
    if (bus.pc !== 64'h100) begin
      n_fail++;
      $display("FAIL b_pc got %h required 100", bus.pc);
    end
    retire(1'b0, 1'b1, 1'b0, 64'd3);
    n_tests++;
    if (bus.imem_addr !== 64'h10C) begin
      n_fail++;
      $display("FAIL b_target got %h required 10c", bus.imem_addr);
    end
  endtask

  task automatic test_stall;
    start(1'b0);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({bus.imem_req, bus.instr_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL stall[%0d] req/valid got %b required 10",
                 i, {bus.imem_req, bus.instr_valid});
      end
      @(negedge CLK);
    end
    bus.imem_ack = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h8B02_0020) begin
      n_fail++;
      $display("FAIL stall_issue valid %b instr %h required 1 8b020020",
               bus.instr_valid, bus.instr);
    end
    spur = 1'b1;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_tests++;
      if (bus.instr !== 32'h8B02_0020 || bus.pc !== 64'h0
          || {bus.imem_req, bus.instr_valid} !== 2'b01) begin
        n_fail++;
        $display("FAIL hold[%0d] instr %h pc %h rv %b required 8b020020 0 01",
                 i, bus.instr, bus.pc,
                 {bus.imem_req, bus.instr_valid});
      end
    end
`ifdef FETCH_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL stall_cnt got %0d required 3", stall_cnt);
    end
`endif
    spur = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (bus.imem_addr !== 64'h4 || bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL release addr got %h required 4", bus.imem_addr);
    end
  endtask

  task automatic test_async_reset;
    start(1'b1);
    wait_issue("ar_a");
    bus.imem_ack = 1'b0;
    retire(1'b0, 1'b1, 1'b0, 64'd16);
    #2 resetl = 1'b0;
    #1;
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_fetch req %b addr %h required 0 0",
               bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1;
    spur = 1'b1;
    @(negedge CLK);
    #2 resetl = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (bus.instr !== 32'h0 || bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL late_ack instr %h req %b required 0 1",
               bus.instr, bus.imem_req);
    end
    spur = 1'b0;
    wait_issue("ar_b");
    retire(1'b0, 1'b1, 1'b0, 64'd16);
    bus.instr_ready = 1'b0;
    wait_issue("ar_c");
    #2 resetl = 1'b0;
    #1;
    n_tests++;
    if (bus.instr_valid !== 1'b0 || bus.pc !== 64'h0
        || bus.instr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_issue valid %b pc %h instr %h required 0 0 0",
               bus.instr_valid, bus.pc, bus.instr);
    end
    @(negedge CLK);
  endtask

  task automatic test_wrap;
    start(1'b1);
    wait_issue("wrap_a");
    retire(1'b0, 1'b1, 1'b0, -64'sd1);
    n_tests++;
    if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++;
      $display("FAIL neg_off got %h required fffffffffffffffc",
               bus.imem_addr);
    end
    wait_issue("wrap_b");
    retire(1'b0, 1'b0, 1'b0, 64'd0);
    n_tests++;
    if (bus.imem_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL wrap got %h required 0", bus.imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_opcode();
    test_cbz();
    test_uncond();
    test_stall();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
